alu_writeback: RTL and testbench

Write side of the operand register file. Accepts 33-bit ALU results (32-bit sum plus carry-out) with a destination index over a valid/ready handshake. Buffers them in a small FIFO and commits them into the register file and carry flag when the shared write port is granted. Provides two combinational read ports with forwarding from pending entries, so the adder's operand reads always see the newest value.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_writeback_if.sv | 13 +
 rtl/wb_fifo.sv | 83 ++++++++
 rtl/alu_writeback.sv | 90 +++++++++
 tb/tb_alu_writeback.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU write-back path: operand width, register index
// and the pending-result entry carried through the write-back FIFO.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 4;
    localparam int RD_W   = $clog2(NREGS);

    typedef logic [DATA_W:0]  result_t;
    typedef logic [RD_W-1:0]  rd_idx_t;

    typedef struct packed {
        rd_idx_t rd;
        result_t result;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_if.sv
// Result handshake from the adder into the write-back block.
interface alu_writeback_if;
    import alu_pkg::*;

    logic    in_valid;
    logic    in_ready;
    rd_idx_t in_rd;
    result_t in_result;

    modport master (output in_valid, output in_rd, output in_result, input in_ready);
    modport slave  (input in_valid, input in_rd, input in_result, output in_ready);

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending write-back entries; exposes every slot with a
// valid bit and the head pointer so the owner can search by age.
module wb_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  wb_entry_t                push_data_i,
    input  logic                     pop_i,
    output wb_entry_t                pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH)-1:0] head_o,
    output wb_entry_t                entries_o [DEPTH],
    output logic [DEPTH-1:0]         valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t         mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;
    logic [PTR_W-1:0]  offset;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) tail_d = tail_q + PTR_W'(1);
        if (do_pop)  head_d = head_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; slot validity comes only from the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= push_data_i;
    end

    always_comb begin
        valid_o = '0;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset     = PTR_W'(i) - head_q;
            valid_o[i] = ({1'b0, offset} < count_q);
        end
    end

    assign entries_o  = mem_q;
    assign pop_data_o = mem_q[head_q];
    assign count_o    = count_q;
    assign head_o     = head_q;

endmodule

// File: rtl/alu_writeback.sv
// Write side of the operand register file: buffers ALU results, commits them
// in order on the shared write port, and forwards pending values to readers.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_writeback_if.slave         wb,
    input  logic                   commit_en,
    input  rd_idx_t                rd_addr_a,
    output logic [DATA_W-1:0]      rd_data_a,
    input  rd_idx_t                rd_addr_b,
    output logic [DATA_W-1:0]      rd_data_b,
    output logic                   carry_flag,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] regfile_q [NREGS];
    logic [DATA_W-1:0] regfile_d [NREGS];
    logic              carry_q, carry_d;

    wb_entry_t         push_entry;
    wb_entry_t         head_entry;
    wb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  slot_valid;
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  slot;
    logic              fifo_full, fifo_empty;
    logic              commit;

    assign push_entry = '{rd: wb.in_rd, result: wb.in_result};
    // Ready depends only on stored occupancy, never on this cycle's commit.
    assign wb.in_ready = !fifo_full;
    assign commit      = commit_en && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (wb.in_valid),
        .push_data_i (push_entry),
        .pop_i       (commit),
        .pop_data_o  (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (pending),
        .head_o      (head_ptr),
        .entries_o   (entries),
        .valid_o     (slot_valid)
    );

    always_comb begin
        regfile_d = regfile_q;
        carry_d   = carry_q;
        if (commit) begin
            regfile_d[head_entry.rd] = head_entry.result[DATA_W-1:0];
            carry_d                  = head_entry.result[DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regfile_q[r] <= '0;
            carry_q <= 1'b0;
        end else begin
            regfile_q <= regfile_d;
            carry_q   <= carry_d;
        end
    end

    // Walk pending slots oldest to youngest so the youngest match is the last one written.
    always_comb begin
        rd_data_a = regfile_q[rd_addr_a];
        rd_data_b = regfile_q[rd_addr_b];
        slot      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_ptr + PTR_W'(k);
            if (slot_valid[slot] && entries[slot].rd == rd_addr_a)
                rd_data_a = entries[slot].result[DATA_W-1:0];
            if (slot_valid[slot] && entries[slot].rd == rd_addr_b)
                rd_data_b = entries[slot].result[DATA_W-1:0];
        end
    end

    assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized
// traffic compared against a queue-based model of the write-back path.
module tb_alu_writeback;
    import alu_pkg::*;

    localparam int DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   commit_en;
    rd_idx_t                rd_addr_a, rd_addr_b;
    logic [DATA_W-1:0]      rd_data_a, rd_data_b;
    logic                   carry_flag;
    logic [$clog2(DEPTH):0] pending;

    int tests = 0;
    int fails = 0;

    wb_entry_t         m_q [$];
    logic [DATA_W-1:0] m_regs [NREGS];
    logic              m_carry;

    always #5 clk = ~clk;

    alu_writeback_if wb_if ();

    alu_writeback #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wb_if.slave),
        .commit_en  (commit_en),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .carry_flag (carry_flag),
        .pending    (pending)
    );

    function automatic logic [DATA_W-1:0] m_read(rd_idx_t a);
        logic [DATA_W-1:0] v;
        v = m_regs[a];
        foreach (m_q[i]) if (m_q[i].rd == a) v = m_q[i].result[DATA_W-1:0];
        return v;
    endfunction

    function automatic result_t rand_result();
        return {$urandom_range(0, 1) == 1, 32'($urandom())};
    endfunction

    task automatic drive(input logic v, input rd_idx_t rd, input result_t res,
                         input logic c, input rd_idx_t a, input rd_idx_t b);
        wb_if.in_valid  = v;
        wb_if.in_rd     = rd;
        wb_if.in_result = res;
        commit_en       = c;
        rd_addr_a       = a;
        rd_addr_b       = b;
        #1;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        bit        do_push, do_pop;
        wb_entry_t e;
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            foreach (m_regs[r]) m_regs[r] = '0;
            m_carry = 1'b0;
        end else begin
            do_push = wb_if.in_valid && (m_q.size() < DEPTH);
            do_pop  = commit_en && (m_q.size() > 0);
            if (do_pop) begin
                e = m_q.pop_front();
                m_regs[e.rd] = e.result[DATA_W-1:0];
                m_carry      = e.result[DATA_W];
            end
            if (do_push) begin
                e.rd     = wb_if.in_rd;
                e.result = wb_if.in_result;
                m_q.push_back(e);
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 2'd1, 33'h1_FFFFFFFF, 1'b1, 2'd0, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, '0, 1'b0, 2'd0, 2'd0);
        for (int a = 0; a < NREGS; a++) begin
            drive(1'b0, 2'd0, '0, 1'b0, rd_idx_t'(a), rd_idx_t'(NREGS - 1 - a));
            tests++;
            if (rd_data_a !== '0 || rd_data_b !== '0) begin
                fails++;
                $display("FAIL reset_reg%0d: a=%h b=%h expected 0", a, rd_data_a, rd_data_b);
            end
        end
        tests++;
        if (carry_flag !== 1'b0 || wb_if.in_ready !== 1'b1 || pending !== '0) begin
            fails++;
            $display("FAIL reset_state: carry=%b ready=%b pending=%0d expected 0/1/0",
                     carry_flag, wb_if.in_ready, pending);
        end
    endtask

    task automatic test_single_commit();
        drive(1'b1, 2'd2, 33'h1_9D9D9D9C, 1'b1, 2'd2, 2'd2);
        tests++;
        if (rd_data_a !== 32'h0) begin
            fails++;
            $display("FAIL single_no_same_cycle_fwd: rd_data_a=%h expected 00000000", rd_data_a);
        end
        tick();
        drive(1'b0, 2'd0, '0, 1'b1, 2'd2, 2'd2);
        tests++;
        if (rd_data_a !== 32'h9D9D9D9C || pending !== 2'd1) begin
            fails++;
            $display("FAIL single_fwd: rd_data_a=%h pending=%0d expected 9d9d9d9c/1", rd_data_a, pending);
        end
        tick();
        tests++;
        if (rd_data_a !== 32'h9D9D9D9C || carry_flag !== 1'b1 || pending !== 2'd0) begin
            fails++;
            $display("FAIL single_commit: r2=%h carry=%b pending=%0d expected 9d9d9d9c/1/0",
                     rd_data_a, carry_flag, pending);
        end
    endtask

    task automatic test_youngest_forward();
        drive(1'b1, 2'd0, 33'h1_00000000, 1'b0, 2'd0, 2'd3);
        tick();
        drive(1'b1, 2'd0, 33'h0_00000002, 1'b0, 2'd0, 2'd3);
        tick();
        drive(1'b0, 2'd0, '0, 1'b0, 2'd0, 2'd3);
        tests++;
        if (wb_if.in_ready !== 1'b0 || pending !== 2'd2 || rd_data_a !== 32'h2) begin
            fails++;
            $display("FAIL youngest_full: ready=%b pending=%0d a=%h expected 0/2/00000002",
                     wb_if.in_ready, pending, rd_data_a);
        end
        drive(1'b0, 2'd0, '0, 1'b1, 2'd0, 2'd3);
        tick();
        tests++;
        if (carry_flag !== 1'b1 || pending !== 2'd1 || rd_data_a !== 32'h2) begin
            fails++;
            $display("FAIL youngest_first_commit: carry=%b pending=%0d a=%h expected 1/1/00000002",
                     carry_flag, pending, rd_data_a);
        end
        tick();
        tests++;
        if (carry_flag !== 1'b0 || pending !== 2'd0 || rd_data_a !== 32'h2) begin
            fails++;
            $display("FAIL youngest_second_commit: carry=%b pending=%0d a=%h expected 0/0/00000002",
                     carry_flag, pending, rd_data_a);
        end
    endtask

    task automatic test_full_wrap();
        drive(1'b1, 2'd1, rand_result(), 1'b0, 2'd1, 2'd3);
        tick();
        drive(1'b1, 2'd3, rand_result(), 1'b0, 2'd1, 2'd3);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, rd_idx_t'(k), rand_result(), 1'b1, rd_idx_t'(k), 2'd3);
            tests++;
            if (wb_if.in_ready !== (k != 0) || pending !== m_q.size()) begin
                fails++;
                $display("FAIL wrap_ready%0d: ready=%b pending=%0d expected %b/%0d",
                         k, wb_if.in_ready, pending, k != 0, m_q.size());
            end
            tick();
            tests++;
            if (carry_flag !== m_carry || rd_data_a !== m_read(rd_addr_a) || rd_data_b !== m_read(rd_addr_b)) begin
                fails++;
                $display("FAIL wrap_data%0d: carry=%b a=%h b=%h expected %b/%h/%h", k,
                         carry_flag, rd_data_a, rd_data_b, m_carry, m_read(rd_addr_a), m_read(rd_addr_b));
            end
        end
        drive(1'b0, 2'd0, '0, 1'b1, 2'd0, 2'd0);
        tick();
        tick();
        for (int a = 0; a < NREGS; a++) begin
            drive(1'b0, 2'd0, '0, 1'b1, rd_idx_t'(a), rd_idx_t'(a));
            tests++;
            if (rd_data_a !== m_regs[a] || pending !== '0) begin
                fails++;
                $display("FAIL wrap_drain_r%0d: got %h pending=%0d expected %h/0", a, rd_data_a, pending, m_regs[a]);
            end
        end
    endtask

    task automatic test_dual_read();
        drive(1'b1, 2'd1, 33'h0_00000001, 1'b1, 2'd1, 2'd1);
        tick();
        drive(1'b0, 2'd0, '0, 1'b1, 2'd1, 2'd1);
        tests++;
        if (rd_data_a !== 32'h1 || rd_data_b !== 32'h1 || pending !== 2'd1) begin
            fails++;
            $display("FAIL dual_fwd: a=%h b=%h pending=%0d expected 00000001/00000001/1",
                     rd_data_a, rd_data_b, pending);
        end
        tick();
        tests++;
        if (rd_data_a !== 32'h1 || rd_data_b !== 32'h1 || pending !== 2'd0 || carry_flag !== 1'b0) begin
            fails++;
            $display("FAIL dual_reg: a=%h b=%h pending=%0d carry=%b expected 00000001/00000001/0/0",
                     rd_data_a, rd_data_b, pending, carry_flag);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, rd_idx_t'($urandom_range(0, NREGS - 1)), rand_result(),
                  $urandom_range(0, 2) != 0, rd_idx_t'($urandom_range(0, NREGS - 1)),
                  rd_idx_t'($urandom_range(0, NREGS - 1)));
            tests++;
            if (wb_if.in_ready !== (m_q.size() < DEPTH) || pending !== m_q.size() ||
                carry_flag !== m_carry || rd_data_a !== m_read(rd_addr_a) ||
                rd_data_b !== m_read(rd_addr_b)) begin
                fails++;
                $display("FAIL random%0d: ready=%b pend=%0d carry=%b a=%h b=%h expected %b/%0d/%b/%h/%h",
                         n, wb_if.in_ready, pending, carry_flag, rd_data_a, rd_data_b,
                         m_q.size() < DEPTH, m_q.size(), m_carry, m_read(rd_addr_a), m_read(rd_addr_b));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 2'd2, 33'h1_12345678, 1'b0, 2'd2, 2'd3);
        tick();
        drive(1'b1, 2'd3, 33'h1_87654321, 1'b0, 2'd2, 2'd3);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 2'd1, 33'h1_0000ABCD, 1'b1, 2'd2, 2'd3);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, '0, 1'b1, 2'd2, 2'd3);
        tests++;
        if (pending !== '0 || wb_if.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_state: pending=%0d ready=%b expected 0/1", pending, wb_if.in_ready);
        end
        tick();
        tick();
        for (int a = 0; a < NREGS; a++) begin
            drive(1'b0, 2'd0, '0, 1'b1, rd_idx_t'(a), rd_idx_t'(a));
            tests++;
            if (rd_data_a !== '0 || carry_flag !== 1'b0 || pending !== '0) begin
                fails++;
                $display("FAIL midreset_r%0d: got %h carry=%b pending=%0d expected 0/0/0",
                         a, rd_data_a, carry_flag, pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_commit();
        test_youngest_forward();
        test_full_wrap();
        test_dual_read();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
